mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
//  Synthesizable self-checking monitor on the core data-memory write port (MemWrite/DataAdr/WriteData).
//  Holds a programmable, ordered list of expected (address, data) stores and flags pass/fail on-chip.
//  Writes to a scratch address are ignored; a watchdog catches hangs.
//  Sits beside riscv top; replaces single-value bench checks for GCD/LCM coprocessor regressions.
// PARAMETERS
//  ADDR_W     32    width of DataAdr and expected-address entries
//  DATA_W     32    width of WriteData and expected-data entries
//  DEPTH      8     max expected-store entries; IDX_W = $clog2(DEPTH)
//  IGNORE_ADR 96    stores to this address are never checked or counted
//  STRICT     1     1: any non-ignored mismatching store fails; 0: mismatching stores skipped silently
//  TIMEOUT    4096  max cycles in ARMED without a match before failing; 0 disables the watchdog
//  TO_W       16    watchdog counter width; must hold TIMEOUT
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  cfg_we     in   1        write expected entry cfg_idx; accepted only in IDLE/PASS/FAIL
//  cfg_idx    in   IDX_W    entry index
//  cfg_addr   in   ADDR_W   expected store address
//  cfg_data   in   DATA_W   expected store data
//  cfg_len    in   IDX_W+1  number of valid entries, sampled on start; legal range 0..DEPTH
//  start      in   1        one-cycle pulse: arm checker
//  MemWrite   in   1        store strobe from core
//  DataAdr    in   ADDR_W   store address
//  WriteData  in   DATA_W   store data
//  armed      out  1        checker in ARMED
//  done       out  1        sticky: PASS or FAIL reached
//  pass       out  1        sticky pass
//  fail       out  1        sticky fail
//  err_code   out  3        0 none, 1 addr mismatch, 2 data mismatch, 3 timeout, 4 bad cfg_len
//  match_cnt  out  IDX_W+1  expected entries matched so far
//  err_adr    out  ADDR_W   DataAdr of the failing store; 0 on timeout
//  err_data   out  DATA_W   WriteData of the failing store; 0 on timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; ptr, len and watchdog cleared; expected table NOT cleared.
//  Timing: all outputs registered; a store sampled at edge k is reflected in the outputs after edge k.
//  FSM IDLE -> ARMED on start: latch len=cfg_len; clear ptr, match_cnt, watchdog, err_*; drop done/pass/fail.
//   cfg_len > DEPTH -> FAIL with err_code=4.
//   cfg_len == 0 -> PASS at the next edge.
//  In PASS or FAIL, start re-arms exactly as from IDLE. start while ARMED also restarts (clears progress).
//  ARMED, each edge with MemWrite=1:
//   DataAdr==IGNORE_ADR: no effect (checked before anything else, even if it equals the expected address).
//   DataAdr==exp_addr[ptr] and WriteData==exp_data[ptr]: match. ptr++, match_cnt++, watchdog cleared.
//     If ptr+1==len -> PASS.
//   DataAdr==exp_addr[ptr] and data differs: STRICT -> FAIL, err_code=2; else skipped.
//   Any other address: STRICT -> FAIL, err_code=1; else skipped.
//   On FAIL, err_adr and err_data capture the offending store.
//  Watchdog (TIMEOUT>0): increments every ARMED cycle without a match.
//   Reaching TIMEOUT -> FAIL, err_code=3. A match in that same cycle wins over the timeout.
//  Priority within a cycle: reset > start > store evaluation > watchdog.
//  cfg_we while ARMED: ignored, table unchanged. cfg_we and start in the same cycle: entry written, then arm.
//  MemWrite is ignored in IDLE, PASS and FAIL; outputs hold until start or reset.
//  Reset mid-ARMED: return to IDLE immediately; no partial pass or fail.
// TESTING
//  T1 table {(100,25)}, len=1, start; stores (96,7),(100,25)
//     -> pass=1, done=1 the edge after (100,25); match_cnt=1; err_code=0.
//  T2 STRICT=1, table {(100,25)}; store (100,24)
//     -> fail=1, err_code=2, err_adr=100, err_data=24.
//  T3 STRICT=1, table {(100,25),(104,5)}; stores (100,25),(108,5)
//     -> fail=1, err_code=1, err_adr=108, match_cnt=1.
//  T4 TIMEOUT=16, len=1, no stores
//     -> fail=1, err_code=3 exactly 16 cycles after arming.
//  T5 STRICT=0; stores (200,1),(100,25) -> pass=1.
//     Separately: cfg_len=0 -> pass next edge; cfg_len=DEPTH+1 -> fail, err_code=4.
//  T6 reset asserted mid-ARMED after 1 of 2 matches
//     -> all outputs 0 next edge; re-arm with start and pass with the original table contents.

Source files
------------

// File: rtl/mem_write_checker.sv
// Store-port monitor: compares core stores against an ordered table of expected
// (address, data) pairs and latches a sticky pass/fail verdict with error details.
module mem_write_checker #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int IGNORE_ADR = 96,
  parameter int STRICT     = 1,
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_len,
  input  logic              start,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              armed,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        err_code,
  output logic [IDX_W:0]    match_cnt,
  output logic [ADDR_W-1:0] err_adr,
  output logic [DATA_W-1:0] err_data
);

  localparam logic [ADDR_W-1:0] IGNORE_L  = ADDR_W'(IGNORE_ADR);
  localparam logic [IDX_W:0]    DEPTH_L   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]    ONE_L     = (IDX_W+1)'(1);
  localparam logic [TO_W-1:0]   TIMEOUT_L = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_ONE_L  = TO_W'(1);

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_ADDR = 3'd1;
  localparam logic [2:0] ERR_DATA = 3'd2;
  localparam logic [2:0] ERR_TO   = 3'd3;
  localparam logic [2:0] ERR_LEN  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

  state_t            r_state;
  logic [IDX_W:0]    r_len;
  logic [IDX_W:0]    r_ptr;
  logic [TO_W-1:0]   r_wd;
  logic              r_armed;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic [2:0]        r_err_code;
  logic [ADDR_W-1:0] r_err_adr;
  logic [DATA_W-1:0] r_err_data;

  // Expected-store table; deliberately survives reset so a run can be re-armed.
  logic [ADDR_W-1:0] r_exp_addr [DEPTH];
  logic [DATA_W-1:0] r_exp_data [DEPTH];

  logic              w_tab_we;
  logic [IDX_W-1:0]  w_ptr_idx;
  logic [ADDR_W-1:0] w_exp_addr;
  logic [DATA_W-1:0] w_exp_data;
  logic              w_store;
  logic              w_addr_hit;
  logic              w_match;
  logic              w_strict_miss;
  logic [2:0]        w_miss_code;
  logic              w_last;
  logic [TO_W-1:0]   w_wd_inc;
  logic              w_timeout;

  assign w_tab_we = cfg_we && (r_state != S_ARMED) && !reset;

  always_ff @(posedge clk) begin
    if (w_tab_we) begin
      r_exp_addr[cfg_idx] <= cfg_addr;
      r_exp_data[cfg_idx] <= cfg_data;
    end
  end

  // The scratch address is screened out first so it can never match or fail.
  assign w_ptr_idx     = r_ptr[IDX_W-1:0];
  assign w_exp_addr    = r_exp_addr[w_ptr_idx];
  assign w_exp_data    = r_exp_data[w_ptr_idx];
  assign w_store       = MemWrite && (DataAdr != IGNORE_L);
  assign w_addr_hit    = (DataAdr == w_exp_addr);
  assign w_match       = w_store && w_addr_hit && (WriteData == w_exp_data);
  assign w_strict_miss = (STRICT != 0) && w_store && !w_match;
  assign w_miss_code   = w_addr_hit ? ERR_DATA : ERR_ADDR;
  assign w_last        = ((r_ptr + ONE_L) == r_len);
  assign w_wd_inc      = r_wd + TO_ONE_L;
  assign w_timeout     = (TIMEOUT != 0) && (w_wd_inc == TIMEOUT_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_ptr      <= '0;
      r_wd       <= '0;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_adr  <= '0;
      r_err_data <= '0;
    end else if (start) begin
      r_len      <= cfg_len;
      r_ptr      <= '0;
      r_wd       <= '0;
      r_pass     <= 1'b0;
      r_err_adr  <= '0;
      r_err_data <= '0;
      if (cfg_len > DEPTH_L) begin
        r_state    <= S_FAIL;
        r_armed    <= 1'b0;
        r_done     <= 1'b1;
        r_fail     <= 1'b1;
        r_err_code <= ERR_LEN;
      end else begin
        r_state    <= S_ARMED;
        r_armed    <= 1'b1;
        r_done     <= 1'b0;
        r_fail     <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end else if (r_state == S_ARMED) begin
      if (r_len == '0) begin
        r_state <= S_PASS;
        r_armed <= 1'b0;
        r_done  <= 1'b1;
        r_pass  <= 1'b1;
      end else if (w_match) begin
        // A match also clears the watchdog, so it beats a same-cycle timeout.
        r_ptr <= r_ptr + ONE_L;
        r_wd  <= '0;
        if (w_last) begin
          r_state <= S_PASS;
          r_armed <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= 1'b1;
        end
      end else if (w_strict_miss) begin
        r_state    <= S_FAIL;
        r_armed    <= 1'b0;
        r_done     <= 1'b1;
        r_fail     <= 1'b1;
        r_err_code <= w_miss_code;
        r_err_adr  <= DataAdr;
        r_err_data <= WriteData;
      end else if (w_timeout) begin
        r_state    <= S_FAIL;
        r_armed    <= 1'b0;
        r_done     <= 1'b1;
        r_fail     <= 1'b1;
        r_err_code <= ERR_TO;
      end else if (TIMEOUT != 0) begin
        r_wd <= w_wd_inc;
      end
    end
  end

  assign armed     = r_armed;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign err_code  = r_err_code;
  assign match_cnt = r_ptr;
  assign err_adr   = r_err_adr;
  assign err_data  = r_err_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: a strict/short-watchdog instance and a lenient instance share stimulus
// and are checked every cycle against a transaction-level model of the expected-store list.
module tb_mem_write_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cfg_we, start, MemWrite;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, DataAdr, WriteData;
  logic [3:0]  cfg_len;

  logic        a_armed, a_done, a_pass, a_fail;
  logic [2:0]  a_err_code;
  logic [3:0]  a_match_cnt;
  logic [31:0] a_err_adr, a_err_data;
  logic        b_armed, b_done, b_pass, b_fail;
  logic [2:0]  b_err_code;
  logic [3:0]  b_match_cnt;
  logic [31:0] b_err_adr, b_err_data;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  mem_write_checker #(.STRICT(1), .TIMEOUT(16)) u_a (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .armed(a_armed), .done(a_done),
    .pass(a_pass), .fail(a_fail), .err_code(a_err_code), .match_cnt(a_match_cnt),
    .err_adr(a_err_adr), .err_data(a_err_data));

  mem_write_checker #(.STRICT(0)) u_b (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .armed(b_armed), .done(b_done),
    .pass(b_pass), .fail(b_fail), .err_code(b_err_code), .match_cnt(b_match_cnt),
    .err_adr(b_err_adr), .err_data(b_err_data));

  // Model: 0 idle, 1 armed, 2 pass, 3 fail; the list is consumed in order via m_cnt.
  int          m_st [2];
  int          m_len [2];
  int          m_cnt [2];
  int          m_idle [2];
  int          m_code [2];
  logic [31:0] m_eadr [2];
  logic [31:0] m_edat [2];
  logic [31:0] m_ta [2][8];
  logic [31:0] m_td [2][8];

  function automatic void model_step(input int i);
    bit strict = (i == 0);
    int to = (i == 0) ? 16 : 4096;
    bit hit = 1'b0;
    bit miss = 1'b0;
    if (reset) begin
      m_st[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_idle[i] = 0;
      m_code[i] = 0; m_eadr[i] = 0; m_edat[i] = 0;
      return;
    end
    if (cfg_we && m_st[i] != 1) begin
      m_ta[i][cfg_idx] = cfg_addr;
      m_td[i][cfg_idx] = cfg_data;
    end
    if (start) begin
      m_len[i] = int'(cfg_len); m_cnt[i] = 0; m_idle[i] = 0;
      m_code[i] = 0; m_eadr[i] = 0; m_edat[i] = 0;
      if (m_len[i] > 8) begin m_st[i] = 3; m_code[i] = 4; end
      else m_st[i] = 1;
    end else if (m_st[i] == 1) begin
      if (m_len[i] == 0) begin
        m_st[i] = 2;
      end else begin
        if (MemWrite && DataAdr != 32'd96) begin
          if (DataAdr == m_ta[i][m_cnt[i]] && WriteData == m_td[i][m_cnt[i]]) hit = 1'b1;
          else if (strict) miss = 1'b1;
        end
        if (hit) begin
          m_cnt[i]++;
          m_idle[i] = 0;
          if (m_cnt[i] == m_len[i]) m_st[i] = 2;
        end else if (miss) begin
          m_st[i] = 3;
          m_code[i] = (DataAdr == m_ta[i][m_cnt[i]]) ? 2 : 1;
          m_eadr[i] = DataAdr;
          m_edat[i] = WriteData;
        end else begin
          m_idle[i]++;
          if (m_idle[i] >= to) begin m_st[i] = 3; m_code[i] = 3; end
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  function automatic logic [31:0] mk(input bit ar, input bit dn, input bit ps, input bit fl,
                                     input int code, input int cnt);
    return 32'({ar, dn, ps, fl, 3'(code), 4'(cnt)});
  endfunction

  function automatic logic [31:0] stat(input int i);
    if (i == 0) return 32'({a_armed, a_done, a_pass, a_fail, a_err_code, a_match_cnt});
    return 32'({b_armed, b_done, b_pass, b_fail, b_err_code, b_match_cnt});
  endfunction

  function automatic logic [31:0] model_stat(input int i);
    return mk(m_st[i] == 1, m_st[i] >= 2, m_st[i] == 2, m_st[i] == 3, m_code[i], m_cnt[i]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_a_status", stat(0), model_stat(0));
      chk("cyc_a_err_adr", a_err_adr, m_eadr[0]);
      chk("cyc_a_err_data", a_err_data, m_edat[0]);
      chk("cyc_b_status", stat(1), model_stat(1));
      chk("cyc_b_err_adr", b_err_adr, m_eadr[1]);
      chk("cyc_b_err_data", b_err_data, m_edat[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cfg_we = 1'b0; start = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic cfg(input int idx, input int adr, input int dat);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = 32'(adr); cfg_data = 32'(dat);
    $display("cfg idx=%0d adr=%0d data=%0d", idx, adr, dat);
    step();
  endtask

  task automatic arm(input int len);
    cfg_len = 4'(len); start = 1'b1;
    $display("start len=%0d", len);
    step();
  endtask

  task automatic store(input int adr, input int dat);
    MemWrite = 1'b1; DataAdr = 32'(adr); WriteData = 32'(dat);
    $display("store adr=%0d data=%0d", adr, dat);
    step();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_len = '0; start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_a", stat(0), mk(0, 0, 0, 0, 0, 0));
    chk("reset_b", stat(1), mk(0, 0, 0, 0, 0, 0));

    // T1: scratch store ignored, then the single expected store passes
    cfg(0, 100, 25);
    arm(1);
    chk("t1_armed", stat(0), mk(1, 0, 0, 0, 0, 0));
    store(96, 7);
    chk("t1_ignored", stat(0), mk(1, 0, 0, 0, 0, 0));
    store(100, 25);
    chk("t1_a_pass", stat(0), mk(0, 1, 1, 0, 0, 1));
    chk("t1_b_pass", stat(1), mk(0, 1, 1, 0, 0, 1));

    // T2: data mismatch
    arm(1);
    store(100, 24);
    chk("t2_a_fail", stat(0), mk(0, 1, 0, 1, 2, 0));
    chk("t2_a_err_adr", a_err_adr, 32'd100);
    chk("t2_a_err_data", a_err_data, 32'd24);
    chk("t2_b_skip", stat(1), mk(1, 0, 0, 0, 0, 0));

    // Empty list passes one edge after arming
    arm(0);
    chk("len0_armed", stat(1), mk(1, 0, 0, 0, 0, 0));
    step();
    chk("len0_a_pass", stat(0), mk(0, 1, 1, 0, 0, 0));

    // T3: address mismatch on the second entry
    cfg(1, 104, 5);
    arm(2);
    store(100, 25);
    store(108, 5);
    chk("t3_a_fail", stat(0), mk(0, 1, 0, 1, 1, 1));
    chk("t3_a_err_adr", a_err_adr, 32'd108);
    chk("t3_b_wait", stat(1), mk(1, 0, 0, 0, 0, 1));
    store(104, 5);
    chk("t3_b_pass", stat(1), mk(0, 1, 1, 0, 0, 2));
    chk("t3_a_hold", stat(0), mk(0, 1, 0, 1, 1, 1));

    // T5: lenient mode skips a foreign store
    arm(1);
    store(200, 1);
    chk("t5_a_fail", stat(0), mk(0, 1, 0, 1, 1, 0));
    chk("t5_a_err_adr", a_err_adr, 32'd200);
    store(100, 25);
    chk("t5_b_pass", stat(1), mk(0, 1, 1, 0, 0, 1));

    // Illegal length
    arm(9);
    chk("len9_a", stat(0), mk(0, 1, 0, 1, 4, 0));
    chk("len9_b", stat(1), mk(0, 1, 0, 1, 4, 0));

    // T4: watchdog fires exactly 16 edges after arming
    arm(1);
    repeat (15) step();
    chk("t4_a_before", stat(0), mk(1, 0, 0, 0, 0, 0));
    step();
    chk("t4_a_timeout", stat(0), mk(0, 1, 0, 1, 3, 0));
    chk("t4_a_err_adr", a_err_adr, 32'd0);
    chk("t4_b_armed", stat(1), mk(1, 0, 0, 0, 0, 0));

    // A match on the timeout edge wins
    arm(1);
    repeat (15) step();
    store(100, 25);
    chk("to_match_a", stat(0), mk(0, 1, 1, 0, 0, 1));

    // T6: reset mid-run, then re-arm with the retained table
    arm(2);
    store(100, 25);
    chk("t6_partial", stat(0), mk(1, 0, 0, 0, 0, 1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_reset_a", stat(0), mk(0, 0, 0, 0, 0, 0));
    chk("t6_reset_b", stat(1), mk(0, 0, 0, 0, 0, 0));
    arm(2);
    store(100, 25);
    store(104, 5);
    chk("t6_a_pass", stat(0), mk(0, 1, 1, 0, 0, 2));

    // Table writes while armed are dropped
    arm(1);
    cfg(0, 300, 3);
    store(100, 25);
    chk("cfg_armed_a", stat(0), mk(0, 1, 1, 0, 0, 1));

    // Write and arm in the same cycle uses the new entry
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 32'd100; cfg_data = 32'd26;
    cfg_len = 4'd1; start = 1'b1;
    $display("cfg+start idx=0 adr=100 data=26 len=1");
    step();
    store(100, 26);
    chk("cfg_start_a", stat(0), mk(0, 1, 1, 0, 0, 1));
    store(100, 99);
    chk("post_pass_hold", stat(0), mk(0, 1, 1, 0, 0, 1));

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
